// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among NUM_REQ renderers.
// A tag pipeline follows each granted read through the ROM and returns its data to the owner.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                       pix_clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ*DATA_W-1:0]  rdata,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [ADDR_W-1:0]          rom_addr,
  output logic                       rom_en,
  input  logic [DATA_W-1:0]          rom_data
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TAG_D = ROM_LATENCY + 1;

  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [PTR_W-1:0]            win;
  logic                        any_req;
  logic [ADDR_W-1:0]           rom_addr_q, rom_addr_d;
  logic                        rom_en_q, rom_en_d;
  logic [TAG_D-1:0]            tag_vld_q, tag_vld_d;
  logic [TAG_D-1:0][PTR_W-1:0] tag_id_q, tag_id_d;
  logic [NUM_REQ*DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]          rvalid_q, rvalid_d;

  // Winner is the first active request scanning upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        win     = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any_req && rst_n) gnt[win] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    rom_en_d   = any_req;
    if (any_req) begin
      rom_addr_d = req_addr[int'(win)*ADDR_W +: ADDR_W];
      ptr_d      = (int'(win) == NUM_REQ - 1) ? '0 : PTR_W'(int'(win) + 1);
    end
  end

  // Stage 0 tags the read being issued; the last stage lines up with rom_data.
  always_comb begin
    tag_vld_d = {tag_vld_q[TAG_D-2:0], any_req};
    tag_id_d  = {tag_id_q[TAG_D-2:0], win};
    rdata_d   = rdata_q;
    rvalid_d  = '0;
    if (tag_vld_q[TAG_D-1]) begin
      rdata_d[int'(tag_id_q[TAG_D-1])*DATA_W +: DATA_W] = rom_data;
      rvalid_d[tag_id_q[TAG_D-1]]                       = 1'b1;
    end
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_en   = rom_en_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a scoreboard queue holds expected returns,
// each tagged with the cycle in which its rvalid pulse must appear.
module tb_sprite_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 13;
  localparam int DW   = 16;

  logic               pix_clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ*DW-1:0] rdata;
  logic [NREQ-1:0]    rvalid;
  logic [AW-1:0]      rom_addr;
  logic               rom_en;
  logic [DW-1:0]      rom_data = '0;

  sprite_rom_arbiter #(
    .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1)
  ) dut (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_addr(req_addr),
    .gnt     (gnt),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rom_addr(rom_addr),
    .rom_en  (rom_en),
    .rom_data(rom_data)
  );

  always #5 pix_clk = ~pix_clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    if (a == 13'h0123) return 16'hF81F;
    return {a, 3'b000} ^ 16'h3C5A;
  endfunction

  // Synchronous ROM, one edge from address to data.
  always @(posedge pix_clk) rom_data <= rom_f(rom_addr);

  typedef struct {
    int           due;
    logic [1:0]   id;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] exp_rdata [NREQ];
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  int            mptr;
  int            cyc;
  int            n_chk;
  int            n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle_start();
    @(posedge pix_clk);
    #1;
    cyc++;
  endtask

  task automatic check_returns();
    logic [NREQ-1:0] erv;
    erv = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      erv[sb[0].id]        = 1'b1;
      exp_rdata[sb[0].id]  = sb[0].data;
      void'(sb.pop_front());
    end
    chk("rvalid", 64'(rvalid), 64'(erv));
    chk("rdata", 64'(rdata), {exp_rdata[3], exp_rdata[2], exp_rdata[1], exp_rdata[0]});
  endtask

  task automatic step(input logic [3:0] r, input logic [AW-1:0] a0, a1, a2, a3);
    logic               found;
    logic [1:0]         w;
    logic [NREQ*AW-1:0] av;
    logic [NREQ-1:0]    eg;
    cycle_start();
    chk("rom_en", 64'(rom_en), 64'(exp_en));
    chk("rom_addr", 64'(rom_addr), 64'(exp_addr));
    av       = {a3, a2, a1, a0};
    req      = r;
    req_addr = av;
    found    = 1'b0;
    w        = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && r[(mptr + k) % NREQ]) begin
        found = 1'b1;
        w     = 2'((mptr + k) % NREQ);
      end
    end
    eg = found ? (4'b0001 << w) : 4'b0000;
    @(negedge pix_clk);
    chk("gnt", 64'(gnt), 64'(eg));
    check_returns();
    if (found) begin
      sb.push_back('{cyc + 3, w, rom_f(av[int'(w)*AW +: AW])});
      exp_en   = 1'b1;
      exp_addr = av[int'(w)*AW +: AW];
      mptr     = (int'(w) == NREQ - 1) ? 0 : int'(w) + 1;
    end else begin
      exp_en = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, '0, '0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_start();
      rst_n = 1'b0;
      req   = 4'b1111;
      sb.delete();
      for (int j = 0; j < NREQ; j++) exp_rdata[j] = '0;
      exp_en   = 1'b0;
      exp_addr = '0;
      mptr     = 0;
      @(negedge pix_clk);
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_rom_en", 64'(rom_en), 64'(0));
      chk("rst_rom_addr", 64'(rom_addr), 64'(0));
      check_returns();
    end
    req   = 4'b0000;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;
    cyc      = 0;
    n_chk    = 0;
    n_fail   = 0;
    exp_en   = 1'b0;
    exp_addr = '0;
    mptr     = 0;
    for (int j = 0; j < NREQ; j++) exp_rdata[j] = '0;

    do_reset(3);

    // All four requesting continuously, round-robin with wrap.
    step(4'b1111, 13'h0100, 13'h0201, 13'h0302, 13'h0403);
    step(4'b1111, 13'h0110, 13'h0211, 13'h0312, 13'h0413);
    step(4'b1111, 13'h0120, 13'h0221, 13'h0322, 13'h0423);
    step(4'b1111, 13'h0130, 13'h0231, 13'h0332, 13'h0433);
    step(4'b1111, 13'h0140, 13'h0241, 13'h0342, 13'h0443);
    idle(4);

    // Single requester 2 reading 0x123.
    step(4'b0100, '0, '0, 13'h0123, '0);
    idle(5);

    // Back-to-back reads from requester 1.
    step(4'b0010, '0, 13'd10, '0, '0);
    step(4'b0010, '0, 13'd11, '0, '0);
    step(4'b0010, '0, 13'd12, '0, '0);
    idle(4);

    // Pointer now at 2: requester 0 wins first, then requester 1.
    step(4'b0011, 13'h1ABC, 13'h0F0F, '0, '0);
    step(4'b0011, 13'h1ABD, 13'h0F0F, '0, '0);
    idle(4);

    // Reset with reads in flight: nothing must return afterwards.
    step(4'b1111, 13'h0500, 13'h0501, 13'h0502, 13'h0503);
    step(4'b1111, 13'h0510, 13'h0511, 13'h0512, 13'h0513);
    step(4'b1111, 13'h0520, 13'h0521, 13'h0522, 13'h0523);
    do_reset(2);
    idle(6);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
